// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared types and constants for the data memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which port owns the current access (core or external)
//   CNT_W       : width of the read-latency counter (covers MEM_LATENCY 1..7)
package data_mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_C, OWN_E} arb_owner_t;
    localparam int CNT_W = 3;
endpackage

// File: rtl/data_mem_arbiter_rr.sv
// mem_arb_rr: two-way round-robin picker between the core (bit 0) and external (bit 1) ports.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   req          : request vector {external, core}
//   en           : grant may be taken this cycle; updates the round-robin history
//   grant        : winning port
//   valid        : at least one port is requesting
module mem_arb_rr
    import data_mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       en,
    output arb_owner_t grant,
    output logic       valid
);
    arb_owner_t last_grant;
    // On a tie the port that was not granted last wins; history starts at E so the core wins first.
    always_comb begin
        valid = |req;
        grant = (&req) ? ((last_grant == OWN_C) ? OWN_E : OWN_C) : (req[1] ? OWN_E : OWN_C);
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) last_grant <= OWN_E;
        else if (en && valid) last_grant <= grant;
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: serialises core (C) and external (E) accesses onto the single-port data_mem.
//   clk_i, rst_i                              : clock, asynchronous active-low reset
//   c_req_i/c_we_i/c_size_i/c_addr_i/c_wd_i   : core request, held until c_ack_o
//   c_rd_o, c_ack_o, c_stall_o                : core read data, completion pulse, stall
//   e_req_i/e_we_i/e_size_i/e_addr_i/e_wd_i   : external request, held until e_ack_o
//   e_rd_o, e_ack_o                           : external read data, completion pulse
//   mem_req_o/mem_we_o/mem_size_o/mem_addr_o/mem_wd_o : data_mem request and latched fields
//   mem_rd_i                                  : data_mem read data, MEM_LATENCY cycles after mem_req_o
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [2:0]        c_size_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [31:0]       c_wd_i,
    output logic [31:0]       c_rd_o,
    output logic              c_ack_o,
    output logic              c_stall_o,
    input  logic              e_req_i,
    input  logic              e_we_i,
    input  logic [2:0]        e_size_i,
    input  logic [ADDR_W-1:0] e_addr_i,
    input  logic [31:0]       e_wd_i,
    output logic [31:0]       e_rd_o,
    output logic              e_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_size_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i
);
    arb_state_t       state, state_nx;
    arb_owner_t       owner, grant;
    logic             grant_valid;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata;

    mem_arb_rr u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   ({e_req_i, c_req_i}),
        .en    (state == IDLE),
        .grant (grant),
        .valid (grant_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant_valid ? ISSUE : IDLE;
            ISSUE:   state_nx = mem_we_o ? RESP : WAIT;
            WAIT:    state_nx = (cnt == '0) ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
        mem_req_o = state == ISSUE;
        c_ack_o   = state == RESP && owner == OWN_C;
        e_ack_o   = state == RESP && owner == OWN_E;
        c_rd_o    = c_ack_o ? rdata : '0;
        e_rd_o    = e_ack_o ? rdata : '0;
        // Gated by reset so every output reads 0 while reset is held.
        c_stall_o = rst_i && c_req_i && !c_ack_o;
    end

    // Memory-side fields change only when a grant is taken, so they stay stable through RESP.
    // rdata is cleared on each grant so a write completion returns 0 rather than stale read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner      <= OWN_C;
            mem_we_o   <= 1'b0;
            mem_size_o <= '0;
            mem_addr_o <= '0;
            mem_wd_o   <= '0;
            cnt        <= '0;
            rdata      <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                owner      <= grant;
                mem_we_o   <= (grant == OWN_E) ? e_we_i : c_we_i;
                mem_size_o <= (grant == OWN_E) ? e_size_i : c_size_i;
                mem_addr_o <= (grant == OWN_E) ? e_addr_i : c_addr_i;
                mem_wd_o   <= (grant == OWN_E) ? e_wd_i : c_wd_i;
                rdata      <= '0;
            end
            if (state == ISSUE) cnt <= CNT_W'(MEM_LATENCY - 1);
            if (state == WAIT) begin
                if (cnt == '0) rdata <= mem_rd_i;
                else cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized bench with a transaction-level reference model for data_mem_arbiter.
module tb_data_mem_arbiter;
    localparam int L = 4;

    logic        clk, rst_i;
    logic        c_req, c_we, e_req, e_we;
    logic [2:0]  c_size, e_size;
    logic [31:0] c_addr, c_wd, e_addr, e_wd;
    logic [31:0] c_rd, e_rd, mem_addr, mem_wd, mem_rd;
    logic        c_ack, c_stall, e_ack, mem_req, mem_we;
    logic [2:0]  mem_size;

    data_mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .c_req_i(c_req), .c_we_i(c_we), .c_size_i(c_size), .c_addr_i(c_addr), .c_wd_i(c_wd),
        .c_rd_o(c_rd), .c_ack_o(c_ack), .c_stall_o(c_stall),
        .e_req_i(e_req), .e_we_i(e_we), .e_size_i(e_size), .e_addr_i(e_addr), .e_wd_i(e_wd),
        .e_rd_o(e_rd), .e_ack_o(e_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Environment memory: read data is valid only exactly L cycles after the request, junk otherwise.
    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];
    int age = 15;
    always @(negedge clk) begin
        if (!rst_i) age = 15;
        else if (mem_req) begin
            age = 0;
            if (mem_we) env_mem[mem_addr[9:2]] = mem_wd;
        end else if (age < 15) age++;
        mem_rd = (age == L) ? env_mem[mem_addr[9:2]] : $urandom;
    end

    // Reference model: one transaction at a time, timed from the cycle the request is sampled.
    logic        busy = 0, own = 0, lg = 1, t_we = 0;
    logic        m_we = 0;
    logic [2:0]  m_size = 0;
    logic [31:0] m_addr = 0, m_wd = 0, exp_rd = 0;
    int          t_issue = 0, t_ack = 0;
    int          c_ack_at = -1, e_ack_at = -1, mreq_at = -1, n_acks = 0;
    logic [5:0]  order = 0;
    logic [31:0] c_rd_seen = 0, e_rd_seen = 0;
    logic        c_ack_prev = 0, e_ack_prev = 0;

    always @(negedge clk) begin
        logic ca, ea, win;
        if (!rst_i) begin
            busy = 0; lg = 1; m_we = 0; m_size = 0; m_addr = 0; m_wd = 0;
        end
        ca = busy && !own && cyc == t_ack;
        ea = busy && own && cyc == t_ack;
        chk("c_ack", c_ack, ca);
        chk("e_ack", e_ack, ea);
        chk("c_rd", c_rd, ca ? exp_rd : 32'd0);
        chk("e_rd", e_rd, ea ? exp_rd : 32'd0);
        chk("c_stall", c_stall, rst_i && c_req && !ca);
        chk("mem_req", mem_req, busy && cyc == t_issue);
        chk("mem_we", mem_we, m_we);
        chk("mem_size", mem_size, m_size);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wd", mem_wd, m_wd);
        if (c_ack) begin if (c_ack_at < 0) c_ack_at = cyc; c_rd_seen = c_rd; end
        if (e_ack) begin if (e_ack_at < 0) e_ack_at = cyc; e_rd_seen = e_rd; end
        if (c_ack || e_ack) begin
            if (n_acks < 6) order[n_acks] = e_ack;
            n_acks++;
        end
        if (mem_req && mreq_at < 0) mreq_at = cyc;
        c_ack_prev = c_ack;
        e_ack_prev = e_ack;
        if (rst_i) begin
            if (busy) begin
                if (cyc == t_issue && t_we) ref_mem[m_addr[9:2]] = m_wd;
                if (cyc == t_issue && !t_we) exp_rd = ref_mem[m_addr[9:2]];
                if (cyc == t_ack) busy = 0;
            end else if (c_req || e_req) begin
                win = (c_req && e_req) ? !lg : e_req;
                lg = win; own = win; busy = 1;
                m_we = win ? e_we : c_we;
                m_size = win ? e_size : c_size;
                m_addr = win ? e_addr : c_addr;
                m_wd = win ? e_wd : c_wd;
                t_we = m_we;
                exp_rd = 0;
                t_issue = cyc + 1;
                t_ack = cyc + (m_we ? 2 : 2 + L);
            end
        end
        cyc++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        c_ack_at = -1; e_ack_at = -1; mreq_at = -1; n_acks = 0; order = 0;
    endtask

    task automatic do_reset();
        rst_i = 0; c_req = 0; e_req = 0;
        cycles(2);
        rst_i = 1;
        cycles(1);
    endtask

    task automatic rnd(output logic we, output logic [2:0] sz, output logic [31:0] a, output logic [31:0] w);
        we = 1'($urandom_range(0, 1));
        sz = 3'($urandom_range(0, 7));
        a = $urandom;
        w = $urandom;
    endtask

    int t0;

    initial begin
        rst_i = 0;
        c_req = 0; c_we = 0; c_size = 0; c_addr = 0; c_wd = 0;
        e_req = 0; e_we = 0; e_size = 0; e_addr = 0; e_wd = 0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        env_mem[8] = 32'hCAFEF00D; ref_mem[8] = 32'hCAFEF00D;
        cycles(3);
        chk("reset_ack", {c_ack, e_ack, mem_req}, 0);
        rst_i = 1;
        cycles(1);

        // Simultaneous writes after reset: core first, external next.
        clr(); t0 = cyc;
        c_req = 1; c_we = 1; c_size = 3'd2; c_addr = 32'h40; c_wd = 32'h11112222;
        e_req = 1; e_we = 1; e_size = 3'd2; e_addr = 32'h44; e_wd = 32'h33334444;
        cycles(3); c_req = 0;
        cycles(3); e_req = 0;
        chk("t2_c_ack_cycle", c_ack_at - t0, 2);
        chk("t2_e_ack_cycle", e_ack_at - t0, 5);
        chk("t2_mem_c", env_mem[16], 32'h11112222);
        chk("t2_mem_e", env_mem[17], 32'h33334444);

        // Both ports held continuously: grants alternate starting with the core.
        do_reset();
        clr();
        c_req = 1; c_we = 0; c_addr = 32'h50;
        e_req = 1; e_we = 0; e_addr = 32'h54;
        for (int i = 0; i < 80 && n_acks < 6; i++) cycles(1);
        c_req = 0; e_req = 0;
        chk("t3_order", order, 6'b101010);
        cycles(10);

        // Single core read.
        clr(); t0 = cyc;
        c_req = 1; c_we = 0; c_size = 3'd2; c_addr = 32'h10;
        cycles(7); c_req = 0;
        chk("t1_mem_req_cycle", mreq_at - t0, 1);
        chk("t1_ack_cycle", c_ack_at - t0, 2 + L);
        chk("t1_rd", c_rd_seen, 32'hDEADBEEF);

        // Single external read.
        clr(); t0 = cyc;
        e_req = 1; e_we = 0; e_size = 3'd1; e_addr = 32'h20;
        cycles(7); e_req = 0;
        chk("t4_ack_cycle", e_ack_at - t0, 6);
        chk("t4_rd", e_rd_seen, 32'hCAFEF00D);
        chk("t4_no_c_ack", c_ack_at < 0, 1);

        // Reset while a core read waits on memory.
        clr(); t0 = cyc;
        c_req = 1; c_we = 0; c_addr = 32'h30;
        cycles(3);
        rst_i = 0;
        #1;
        chk("t5_async_addr", mem_addr, 0);
        chk("t5_async_ctl", {mem_we, mem_size, c_stall, c_ack}, 0);
        cycles(1); c_req = 0;
        cycles(1); rst_i = 1;
        clr();
        cycles(10);
        chk("t5_no_ack", c_ack_at < 0, 1);
        clr(); t0 = cyc;
        c_req = 1; c_we = 0; c_addr = 32'h10;
        e_req = 1; e_we = 0; e_addr = 32'h20;
        cycles(7); c_req = 0;
        cycles(7); e_req = 0;
        chk("t5_c_first", c_ack_at - t0, 6);
        chk("t5_e_next", e_ack_at - t0, 13);

        // External request dropped during WAIT; pending core request follows.
        cycles(2);
        clr(); t0 = cyc;
        e_req = 1; e_we = 0; e_addr = 32'h20;
        cycles(3);
        e_req = 0;
        c_req = 1; c_we = 0; c_addr = 32'h10;
        cycles(11); c_req = 0;
        chk("t6_e_ack", e_ack_at - t0, 6);
        chk("t6_c_ack", c_ack_at - t0, 13);
        chk("t6_c_rd", c_rd_seen, 32'hDEADBEEF);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycles(1);
            if (!rst_i) rst_i = 1;
            else if ($urandom_range(0, 399) == 0) rst_i = 0;
            if (c_ack_prev) begin
                c_req = 1'($urandom_range(0, 1));
                rnd(c_we, c_size, c_addr, c_wd);
            end else if (!c_req) begin
                if ($urandom_range(0, 2) == 0) begin c_req = 1; rnd(c_we, c_size, c_addr, c_wd); end
            end else if ($urandom_range(0, 29) == 0) c_req = 0;
            if (e_ack_prev) begin
                e_req = 1'($urandom_range(0, 1));
                rnd(e_we, e_size, e_addr, e_wd);
            end else if (!e_req) begin
                if ($urandom_range(0, 2) == 0) begin e_req = 1; rnd(e_we, e_size, e_addr, e_wd); end
            end else if ($urandom_range(0, 29) == 0) e_req = 0;
        end
        rst_i = 1; c_req = 0; e_req = 0;
        cycles(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
